// File: rtl/contador_param.sv
// Single-register up/down/step/load counter with wrap or saturate at the boundaries,
// registered load/rco pulses and a sticky overflow flag.
module contador_param #(
    parameter int WIDTH = 32,
    parameter     STEP  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             saturate,
    input  logic             clr_ovf,
    output logic             load,
    output logic             rco,
    output logic             ovf,
    output logic [WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DN   = 2'b01,
        MODE_STEP = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // All arithmetic is one bit wider than the counter; the top bit is the carry/borrow.
    localparam logic [WIDTH:0] ONE_X  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] q_q, q_d;
    logic             load_q, load_d;
    logic             rco_q, rco_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   up_x;
    logic [WIDTH:0]   dn_x;
    logic [WIDTH:0]   st_x;

    assign q_ext = {1'b0, q_q};
    assign up_x  = q_ext + ONE_X;
    assign dn_x  = q_ext - ONE_X;
    assign st_x  = q_ext - STEP_X;

    always_comb begin
        q_d    = q_q;
        load_d = 1'b0;
        rco_d  = 1'b0;
        if (enable) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    rco_d = up_x[WIDTH];
                    q_d   = (saturate && up_x[WIDTH]) ? q_q : up_x[WIDTH-1:0];
                end
                MODE_DN: begin
                    rco_d = dn_x[WIDTH];
                    q_d   = (saturate && dn_x[WIDTH]) ? q_q : dn_x[WIDTH-1:0];
                end
                MODE_STEP: begin
                    rco_d = st_x[WIDTH];
                    q_d   = (saturate && st_x[WIDTH]) ? '0 : st_x[WIDTH-1:0];
                end
                MODE_LOAD: begin
                    q_d    = D;
                    load_d = 1'b1;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
        // A boundary crossing in the same cycle as a clear keeps the flag set.
        ovf_d = rco_d | (ovf_q & ~clr_ovf & ~load_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            load_q <= 1'b0;
            rco_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            load_q <= load_d;
            rco_q  <= rco_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign load = load_q;
    assign rco  = rco_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: a 32-bit instance with STEP=3 and a 4-bit rerun.
module tb_contador_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] D;
    logic        saturate;
    logic        clr_ovf;
    logic        load, rco, ovf;
    logic [31:0] Q;

    logic        en4;
    logic [1:0]  mode4;
    logic [3:0]  d4;
    logic        sat4;
    logic        clr4;
    logic        load4, rco4, ovf4;
    logic [3:0]  q4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(32), .STEP(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
        .saturate(saturate), .clr_ovf(clr_ovf),
        .load(load), .rco(rco), .ovf(ovf), .Q(Q)
    );

    contador_param #(.WIDTH(4), .STEP(3)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .mode(mode4), .D(d4),
        .saturate(sat4), .clr_ovf(clr4),
        .load(load4), .rco(rco4), .ovf(ovf4), .Q(q4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] eq, input logic el,
                             input logic er, input logic eo);
        check({tag, ".Q"}, 64'(Q), 64'(eq));
        check({tag, ".load"}, 64'(load), 64'(el));
        check({tag, ".rco"}, 64'(rco), 64'(er));
        check({tag, ".ovf"}, 64'(ovf), 64'(eo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] m, input logic [31:0] d,
                         input logic sat, input logic clr);
        enable   = en;
        mode     = m;
        D        = d;
        saturate = sat;
        clr_ovf  = clr;
        tick();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; mode = 2'b00; D = '0; saturate = 1'b0; clr_ovf = 1'b0;
        en4 = 1'b0; mode4 = 2'b00; d4 = '0; sat4 = 1'b0; clr4 = 1'b0;
        tick();
        check_all("rst_init", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // 1: count up, load, then asynchronous reset between edges
        drive(1, 2'b00, 32'h0, 0, 0);
        check_all("t1_up1", 32'h1, 0, 0, 0);
        drive(1, 2'b00, 32'h0, 0, 0);
        check_all("t1_up2", 32'h2, 0, 0, 0);
        drive(1, 2'b11, 32'h7, 0, 0);
        check_all("t1_load7", 32'h7, 1, 0, 0);
        mode = 2'b00;
        #2 reset = 1'b0;
        #1;
        check_all("t1_async_rst", 32'h0, 0, 0, 0);
        tick();
        check_all("t1_rst_held", 32'h0, 0, 0, 0);
        enable = 1'b0;
        reset  = 1'b1;
        tick();
        check_all("t1_rst_release", 32'h0, 0, 0, 0);

        // 2: load near the top, count through the boundary
        drive(1, 2'b11, 32'hFFFF_FFFE, 0, 0);
        check_all("t2_load", 32'hFFFF_FFFE, 1, 0, 0);
        drive(1, 2'b00, 32'h0, 0, 0);
        check_all("t2_max", 32'hFFFF_FFFF, 0, 0, 0);
        drive(1, 2'b00, 32'h0, 0, 0);
        check_all("t2_wrap", 32'h0, 0, 1, 1);

        // 3: down-count at zero, wrap then saturate
        drive(1, 2'b01, 32'h0, 0, 0);
        check_all("t3_dn_wrap", 32'hFFFF_FFFF, 0, 1, 1);
        drive(1, 2'b11, 32'h0, 0, 0);
        check_all("t3_load0", 32'h0, 1, 0, 0);
        drive(1, 2'b01, 32'h0, 1, 0);
        check_all("t3_dn_sat1", 32'h0, 0, 1, 1);
        drive(1, 2'b01, 32'h0, 1, 0);
        check_all("t3_dn_sat2", 32'h0, 0, 1, 1);

        // 4: step-down by 3
        drive(1, 2'b11, 32'h5, 0, 0);
        check_all("t4_load5a", 32'h5, 1, 0, 0);
        drive(1, 2'b10, 32'h0, 0, 0);
        check_all("t4_step_a1", 32'h2, 0, 0, 0);
        drive(1, 2'b10, 32'h0, 0, 0);
        check_all("t4_step_wrap", 32'hFFFF_FFFF, 0, 1, 1);
        drive(1, 2'b11, 32'h5, 0, 0);
        check_all("t4_load5b", 32'h5, 1, 0, 0);
        drive(1, 2'b10, 32'h0, 1, 0);
        check_all("t4_step_b1", 32'h2, 0, 0, 0);
        drive(1, 2'b10, 32'h0, 1, 0);
        check_all("t4_step_sat", 32'h0, 0, 1, 1);
        drive(1, 2'b11, 32'h3, 0, 0);
        check_all("t4_load3", 32'h3, 1, 0, 0);
        drive(1, 2'b10, 32'h0, 0, 0);
        check_all("t4_step_exact", 32'h0, 0, 0, 0);

        // 5: enable low holds everything, with ovf set beforehand
        drive(1, 2'b11, 32'hFFFF_FFFF, 0, 0);
        check_all("t5_loadmax", 32'hFFFF_FFFF, 1, 0, 0);
        drive(1, 2'b00, 32'h0, 0, 0);
        check_all("t5_wrap", 32'h0, 0, 1, 1);
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 3; c++) begin
                drive(0, 2'(m), 32'hA5A5_0001, 1'(c), 0);
                check_all($sformatf("t5_hold_m%0d_c%0d", m, c), 32'h0, 0, 0, 1);
            end
        end

        // 6: ovf clear interplay, plus saturated up at max re-pulsing rco
        drive(1, 2'b01, 32'h0, 0, 1);
        check_all("t6_set_wins", 32'hFFFF_FFFF, 0, 1, 1);
        drive(0, 2'b00, 32'h0, 0, 1);
        check_all("t6_clr", 32'hFFFF_FFFF, 0, 0, 0);
        drive(1, 2'b00, 32'h0, 1, 0);
        check_all("t6_sat_up1", 32'hFFFF_FFFF, 0, 1, 1);
        drive(1, 2'b00, 32'h0, 1, 0);
        check_all("t6_sat_up2", 32'hFFFF_FFFF, 0, 1, 1);
        drive(0, 2'b00, 32'h0, 0, 0);
        check_all("t6_idle", 32'hFFFF_FFFF, 0, 0, 1);

        // 6: WIDTH=4 rerun
        enable = 1'b0; clr_ovf = 1'b0;
        en4 = 1'b1; mode4 = 2'b11; d4 = 4'hF; sat4 = 1'b0; clr4 = 1'b0;
        tick();
        check("w4_load.Q", 64'(q4), 64'hF);
        check("w4_load.load", 64'(load4), 64'h1);
        mode4 = 2'b00;
        tick();
        check("w4_wrap.Q", 64'(q4), 64'h0);
        check("w4_wrap.rco", 64'(rco4), 64'h1);
        check("w4_wrap.ovf", 64'(ovf4), 64'h1);
        check("w4_wrap.load", 64'(load4), 64'h0);
        mode4 = 2'b10;
        tick();
        check("w4_step.Q", 64'(q4), 64'hD);
        check("w4_step.rco", 64'(rco4), 64'h1);
        en4 = 1'b0; clr4 = 1'b1;
        tick();
        check("w4_clr.ovf", 64'(ovf4), 64'h0);
        check("w4_clr.Q", 64'(q4), 64'hD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
